// File: rtl/sparc_ctrl_pkg.sv
// Shared SPARC instruction-field constants and decode helpers for the integer pipeline controllers.
package sparc_ctrl_pkg;

    localparam logic [1:0] OP_BR    = 2'd0;
    localparam logic [1:0] OP_CALL  = 2'd1;
    localparam logic [1:0] OP_ALU   = 2'd2;
    localparam logic [2:0] OP2_BICC = 3'd2;
    localparam logic [5:0] OP3_JMPL = 6'h38;
    localparam logic [5:0] OP3_UMUL = 6'h0A;
    localparam logic [5:0] OP3_SMUL = 6'h0B;
    localparam logic [5:0] OP3_UDIV = 6'h0E;
    localparam logic [5:0] OP3_SDIV = 6'h0F;
    localparam logic [3:0] COND_BA  = 4'b1000;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } ex_state_e;

    function automatic logic is_bicc(input logic [1:0] op, input logic [2:0] op2);
        return (op == OP_BR) && (op2 == OP2_BICC);
    endfunction

    function automatic logic is_ctrl_xfer(input logic [1:0] op, input logic [2:0] op2,
                                          input logic [5:0] op3);
        return is_bicc(op, op2) || (op == OP_CALL) || ((op == OP_ALU) && (op3 == OP3_JMPL));
    endfunction

    function automatic logic is_mul(input logic [1:0] op, input logic [5:0] op3);
        return (op == OP_ALU) && ((op3 == OP3_UMUL) || (op3 == OP3_SMUL));
    endfunction

    function automatic logic is_div(input logic [1:0] op, input logic [5:0] op3);
        return (op == OP_ALU) && ((op3 == OP3_UDIV) || (op3 == OP3_SDIV));
    endfunction

endpackage

// File: rtl/ex_mc_counter.sv
// Loadable down-counter tracking remaining multi-cycle occupancy of Execute; saturates at zero.
module ex_mc_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage sequencing: issue/hold/bubble decisions, mul/div occupancy, CTI redirect and delay-slot annul.
module ex_pipe_ctrl
    import sparc_ctrl_pkg::*;
#(
    parameter int PC_SIZE = 64,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               de_valid,
    input  logic [1:0]         de_op,
    input  logic [2:0]         de_op2,
    input  logic [5:0]         de_op3,
    input  logic               de_a,
    input  logic [3:0]         de_cond,
    input  logic               ex_taken,
    input  logic [PC_SIZE-1:0] ex_target,
    input  logic               mem_ready,
    output logic               ex_issue,
    output logic               ex_bubble,
    output logic               de_stall,
    output logic               pc_sel,
    output logic [PC_SIZE-1:0] pc_target,
    output logic               mc_busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    ex_state_e state;
    logic br_pend, br_bicc, br_a, br_always;
    logic slot_pend, annul_pend;
    logic in_run, in_slot, annul_now;
    logic issue, bubble, mc_start, br_start;
    logic mul_op, div_op, cti_op;
    logic cnt_zero;

    assign mul_op = is_mul(de_op, de_op3);
    assign div_op = is_div(de_op, de_op3);
    assign cti_op = is_ctrl_xfer(de_op, de_op2, de_op3);

    // The next issued instruction is a delay slot while the CTI sits in Execute
    // or after it resolved without a valid successor being available.
    assign in_run    = (state == RUN);
    assign in_slot   = br_pend | slot_pend;
    assign annul_now = br_pend ? (br_bicc & br_a & (~ex_taken | br_always)) : annul_pend;

    assign issue    = ~reset & in_run & de_valid & mem_ready;
    assign bubble   = issue & in_slot & annul_now;
    assign mc_start = issue & ~bubble & (mul_op | div_op);
    assign br_start = issue & ~in_slot & cti_op;

    assign ex_issue  = issue;
    assign ex_bubble = bubble;
    assign de_stall  = ~reset & (~in_run | ~mem_ready);
    assign mc_busy   = ~reset & ~in_run;

    ex_mc_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (mc_start),
        .load_val (div_op ? DIV_LOAD : MUL_LOAD),
        .dec      (~in_run & mem_ready),
        .zero     (cnt_zero)
    );

    // All state is frozen while Memory back-pressures; this also defers a pending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            br_pend    <= 1'b0;
            br_bicc    <= 1'b0;
            br_a       <= 1'b0;
            br_always  <= 1'b0;
            slot_pend  <= 1'b0;
            annul_pend <= 1'b0;
            pc_sel     <= 1'b0;
            pc_target  <= '0;
        end else if (mem_ready) begin
            pc_sel <= br_pend & ex_taken;
            if (br_pend & ex_taken)
                pc_target <= ex_target;
            br_pend <= br_start;
            if (br_start) begin
                br_bicc   <= is_bicc(de_op, de_op2);
                br_a      <= de_a;
                br_always <= (de_cond == COND_BA);
            end
            slot_pend  <= in_slot & ~issue;
            annul_pend <= in_slot & ~issue & annul_now;
            case (state)
                RUN:     if (mc_start) state <= MC_WAIT;
                MC_WAIT: if (cnt_zero) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/ex_pipe_ctrl.md
Name: ex_pipe_ctrl

Overview:
Sequencing controller for the Execute stage of the SPARC integer pipeline. It decides each cycle whether Execute captures a new instruction from Decode, holds it, or captures a bubble. It handles memory back-pressure, multi-cycle multiply/divide occupancy, and control-transfer redirects, including SPARC delay-slot annulment.

Parameters:
PC_SIZE, 64, width of PC and branch target
MUL_LAT, 4, cycles Execute is occupied by UMUL/SMUL (>=2)
DIV_LAT, 16, cycles Execute is occupied by UDIV/SDIV (>=2)

Ports:
clk  in  1  clock
reset  in  1  reset
de_valid  in  1  Decode presents a valid instruction
de_op  in  2  op field of the Decode instruction
de_op2  in  3  op2 field
de_op3  in  6  op3 field
de_a  in  1  annul bit
de_cond  in  4  cond field
ex_taken  in  1  ALU branch-taken (mux select) for the instruction now in Execute
ex_target  in  PC_SIZE  ALU target address for the instruction now in Execute
mem_ready  in  1  Memory stage can accept a result
ex_issue  out  1  Execute captures Decode outputs this cycle
ex_bubble  out  1  Execute captures a NOP instead of Decode outputs
de_stall  out  1  Fetch/Decode hold their current instruction
pc_sel  out  1  Fetch loads pc_target next cycle
pc_target  out  PC_SIZE  redirect address
mc_busy  out  1  a multi-cycle op occupies Execute

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. State=RUN, counter=0, all flags clear, all outputs 0.
- Issue-time classification:
  - ctrl-xfer: Bicc (op=0, op2=2), CALL (op=1), JMPL (op=2, op3=0x38).
  - mc: op=2 with op3 in {0x0A, 0x0B}, latency MUL_LAT; op3 in {0x0E, 0x0F}, latency DIV_LAT.
- States:
  - RUN: ex_issue = de_valid & mem_ready. de_stall = ~mem_ready.
    - Issue of an mc op: load counter with LAT-1, go to MC_WAIT.
    - Issue of a ctrl-xfer: set br_pend and latch is_bicc, a, and (cond==4'b1000).
  - MC_WAIT: ex_issue=0, de_stall=1, mc_busy=1.
    - Counter decrements only when mem_ready=1.
    - Leave to RUN in the cycle the counter is 0 and mem_ready=1. That cycle is the result-valid cycle; no issue occurs in it.
- Redirect and annul:
  - Resolution cycle: the cycle after a ctrl-xfer issue, when ex_taken/ex_target are valid.
  - If ex_taken: pc_sel=1 for exactly one cycle and pc_target<=ex_target (registered; pc_sel and pc_target are asserted together, the cycle after resolution).
  - Annul the delay slot (next instruction issued) if is_bicc & a & (~ex_taken | cond_always). The annulled slot issues with ex_bubble=1 (ex_issue=1, Decode advances).
  - CALL/JMPL never annul.
  - Neither a delay-slot instruction nor an annulled slot starts a new br_pend.
- mem_ready=0 freezes everything:
  - no issue, de_stall=1, counter held.
  - Pending redirect/annul flags held; a pending pc_sel is deferred until mem_ready=1.
  - The resolution cycle is still sampled when Execute holds a frozen ctrl-xfer: ex_taken is stable while frozen.
- de_valid=0 in RUN: no issue. A pending annul waits for the next valid instruction.
- Simultaneous mc issue as a delay slot: annul wins; no MC_WAIT entry.
- ex_bubble implies ex_issue. de_stall and ex_issue are never both 1.

Decomposition:
- Package sparc_ctrl_pkg holds:
  - op/op2/op3 constants: OP_BR=0, OP_CALL=1, OP_ALU=2, OP2_BICC=2, OP3_JMPL=0x38, OP3_UMUL=0x0A, OP3_SMUL=0x0B, OP3_UDIV=0x0E, OP3_SDIV=0x0F, COND_BA=4'b1000.
  - State enum {RUN, MC_WAIT}.
- One sub-module, ex_mc_counter: a loadable down-counter with hold enable and a zero flag.

Test Plan:
- mem_ready=1; ADD, ADD, ADD on consecutive cycles -> ex_issue=1 each cycle; de_stall=0; pc_sel=0.
- UMUL issued, MUL_LAT=4 -> mc_busy=1 and de_stall=1 for 4 cycles; next ADD issues in cycle 5.
- BNE a=1, ex_taken=0 -> delay slot gets ex_bubble=1; pc_sel stays 0.
- BA a=1, ex_taken=1, ex_target=0x4000 -> pc_sel=1 for one cycle with pc_target=0x4000; delay slot ex_bubble=1.
- CALL, ex_taken=1, ex_target=0x2000, with mem_ready=0 for 3 cycles at resolution -> pc_sel deferred; asserted exactly once with 0x2000 after mem_ready=1; delay slot not annulled.
- reset=1 mid-UDIV with counter=7 -> next cycle state=RUN, mc_busy=0, all outputs 0.
